// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat
//   Conditions two raw, bouncing, active-low push buttons (bit0 = up, bit1 = down) for the PWM
//   brightness controller. Each button is synchronized and debounced, then produces one-cycle step
//   pulses. A held button auto-repeats.
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      synchronous active-low reset
//     key_in_n   raw buttons, active-low, asynchronous to clk
//     key_out    registered one-cycle step pulses (2'b01 up, 2'b10 down, never 2'b11)
//     key_level  registered debounced pressed level, active-high
//
//   Build option
//     KEY_AUTO_REPEAT_EN  when defined, holding a button repeats the step pulse after REP_DELAY
//                         cycles and then every REP_PERIOD cycles. When undefined, each debounced
//                         press yields exactly one pulse and REP_DELAY/REP_PERIOD are ignored.
//
//   CNT_W must be wide enough to hold max(DEB_CYCLES, REP_DELAY, REP_PERIOD).
module key_debounce_repeat #(
   parameter int unsigned DEB_CYCLES = 1000000,
   parameter int unsigned REP_DELAY  = 25000000,
   parameter int unsigned REP_PERIOD = 2500000,
   parameter int unsigned CNT_W      = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] key_in_n,
   output logic [1:0] key_out,
   output logic [1:0] key_level
);

   typedef enum logic [2:0] {
      StIdle,
      StDbPress,
      StPressed,
      StRepeat,
      StDbRelease
   } state_e;

   if (DEB_CYCLES < 2 || REP_DELAY < 2 || REP_PERIOD < 2) begin : g_param_check
      $error("key_debounce_repeat: DEB_CYCLES, REP_DELAY and REP_PERIOD must be at least 2");
   end

   logic [1:0] sync1_q, sync2_q;
   logic [1:0] step;      // per-channel pulse raised on this edge's transition
   logic [1:0] level_d;   // per-channel level after this edge's transition
   logic [1:0] key_out_d;

   for (genvar g = 0; g < 2; g++) begin : g_chan
      state_e             state_q, state_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d;
      logic               pressed;
      logic               step_c;

      assign pressed = ~sync2_q[g];

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         step_c  = 1'b0;
         case (state_q)
            StIdle: begin
               if (pressed) begin
                  state_d = StDbPress;
                  cnt_d   = '0;
               end
            end
            StDbPress: begin
               if (!pressed) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                  state_d = StPressed;
                  cnt_d   = '0;
                  step_c  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StPressed: begin
               if (!pressed) begin
                  state_d = StDbRelease;
                  cnt_d   = '0;
`ifdef KEY_AUTO_REPEAT_EN
               end else if (cnt_q == CNT_W'(REP_DELAY - 1)) begin
                  state_d = StRepeat;
                  cnt_d   = '0;
                  step_c  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`else
               end else begin
                  cnt_d = '0;
               end
`endif
            end
`ifdef KEY_AUTO_REPEAT_EN
            StRepeat: begin
               if (!pressed) begin
                  state_d = StDbRelease;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(REP_PERIOD - 1)) begin
                  cnt_d  = '0;
                  step_c = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`endif
            StDbRelease: begin
               // A bounce back to pressed counts as still held; the repeat delay restarts.
               if (pressed) begin
                  state_d = StPressed;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      assign step[g]    = step_c;
      assign level_d[g] = (state_d == StPressed) || (state_d == StRepeat) ||
                          (state_d == StDbRelease);
   end

   // Pulses are combined from next-state values so they land with the FSM transition.
   // Coincident pulses, or any pulse while both buttons are held, are dropped.
   always_comb begin
      key_out_d = 2'b00;
      if ((step == 2'b01 || step == 2'b10) && level_d != 2'b11) begin
         key_out_d = step;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= 2'b11;
         sync2_q   <= 2'b11;
         key_out   <= 2'b00;
         key_level <= 2'b00;
      end else begin
         sync1_q   <= key_in_n;
         sync2_q   <= sync1_q;
         key_out   <= key_out_d;
         key_level <= level_d;
      end
   end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Bench for key_debounce_repeat: directed scenarios with literal pulse timings, then randomized
// button activity, all checked every cycle against a run-length model of the button rules.
module tb_key_debounce_repeat;

   localparam int unsigned DEB = 4;
   localparam int unsigned RD  = 20;
   localparam int unsigned RP  = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] key_in_n = 2'b11;
   logic [1:0] key_out;
   logic [1:0] key_level;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int pulse_log[$];

   always #5 clk = ~clk;

   key_debounce_repeat #(
      .DEB_CYCLES (DEB),
      .REP_DELAY  (RD),
      .REP_PERIOD (RP),
      .CNT_W      (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in_n  (key_in_n),
      .key_out   (key_out),
      .key_level (key_level)
   );

   // Reference model: counts runs of equal synchronized samples per button.
   logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11;
   logic [1:0] m_out = 2'b00, m_lvl = 2'b00;
   int         press_run[2], rel_run[2], since[2];
   bit         deb[2], first[2];

   always @(posedge clk) begin
      logic [1:0] p;
      bit         pr;
      cyc++;
      if (!rst_n) begin
         m_s1 = 2'b11; m_s2 = 2'b11; m_out = 2'b00; m_lvl = 2'b00;
         for (int i = 0; i < 2; i++) begin
            press_run[i] = 0; rel_run[i] = 0; since[i] = 0; deb[i] = 0; first[i] = 0;
         end
      end else begin
         p = 2'b00;
         for (int i = 0; i < 2; i++) begin
            pr = (m_s2[i] == 1'b0);
            if (!deb[i]) begin
               press_run[i] = pr ? press_run[i] + 1 : 0;
               if (press_run[i] == DEB + 1) begin
                  deb[i] = 1; p[i] = 1'b1; since[i] = 0; first[i] = 1;
                  rel_run[i] = 0; press_run[i] = 0;
               end
            end else if (!pr) begin
               rel_run[i]++;
               if (rel_run[i] == DEB + 1) begin
                  deb[i] = 0; rel_run[i] = 0; press_run[i] = 0;
               end
            end else if (rel_run[i] > 0) begin
               rel_run[i] = 0; since[i] = 0; first[i] = 1;
            end else begin
               since[i]++;
`ifdef KEY_AUTO_REPEAT_EN
               if (first[i] && since[i] == RD) begin
                  p[i] = 1'b1; first[i] = 0; since[i] = 0;
               end else if (!first[i] && since[i] == RP) begin
                  p[i] = 1'b1; since[i] = 0;
               end
`endif
            end
            m_lvl[i] = deb[i];
         end
         m_out = ((p == 2'b01 || p == 2'b10) && m_lvl != 2'b11) ? p : 2'b00;
         m_s2  = m_s1;
         m_s1  = key_in_n;
      end
   end

   // Per-cycle compare, sampled on the falling edge.
   always @(negedge clk) begin
      if (cyc > 0) begin
         n_tests++;
         if (key_out !== m_out) begin
            n_fail++;
            $display("FAIL key_out cyc=%0d: got %b want %b", cyc, key_out, m_out);
         end
         n_tests++;
         if (key_level !== m_lvl) begin
            n_fail++;
            $display("FAIL key_level cyc=%0d: got %b want %b", cyc, key_level, m_lvl);
         end
         if (key_out != 2'b00) pulse_log.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Pulse times relative to e0; a missing pulse shows as -1.
   task automatic check_log(input string name, input int e0, input int exp[$]);
      int got;
      check({name, "_count"}, pulse_log.size(), exp.size());
      foreach (exp[i]) begin
         got = (i < pulse_log.size()) ? pulse_log[i] - e0 : -1;
         check($sformatf("%s_pulse%0d", name, i), got, exp[i]);
      end
   endtask

   task automatic idle(input int n);
      key_in_n = 2'b11;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int e0;
      int exp[$];
      int tmr[2];

      repeat (3) @(negedge clk);
      check("reset_key_out", key_out, 2'b00);
      check("reset_key_level", key_level, 2'b00);
      rst_n = 1'b1;
      idle(5);

      // Clean press of up for 10 cycles.
      pulse_log.delete();
      key_in_n = 2'b10; e0 = cyc + 1;
      repeat (7) @(negedge clk);
      check("clean_key_out_e6", key_out, 2'b01);
      check("clean_key_level_e6", key_level, 2'b01);
      repeat (3) @(negedge clk);
      idle(20);
      exp.delete(); exp.push_back(6);
      check_log("clean", e0, exp);

      // Bounce on down: low/high every 2 cycles.
      pulse_log.delete();
      for (int k = 0; k < 20; k++) begin
         key_in_n = {1'(k % 2), 1'b1};
         repeat (2) @(negedge clk);
      end
      idle(20);
      exp.delete();
      check_log("bounce", 0, exp);

      // Up held for 70 cycles.
      pulse_log.delete();
      key_in_n = 2'b10; e0 = cyc + 1;
      repeat (70) @(negedge clk);
      idle(20);
      exp.delete(); exp.push_back(6);
`ifdef KEY_AUTO_REPEAT_EN
      for (int k = 0; k < 10; k++) exp.push_back(26 + 5 * k);
`endif
      check_log("hold", e0, exp);

      // Both pressed together.
      pulse_log.delete();
      key_in_n = 2'b00; e0 = cyc + 1;
      repeat (11) @(negedge clk);
      check("both_key_level", key_level, 2'b11);
      repeat (29) @(negedge clk);
      idle(20);
      exp.delete();
      check_log("both", e0, exp);

      // Reset sampled at edge E0+15 while up stays held; E0+16 is the new first sample.
      pulse_log.delete();
      key_in_n = 2'b10; e0 = cyc + 1;
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_hold_key_out", key_out, 2'b00);
      check("rst_hold_key_level", key_level, 2'b00);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      idle(20);
      exp.delete(); exp.push_back(6); exp.push_back(22);
      check_log("rst_hold", e0, exp);

      // Randomized activity: mix of bounce-length and hold-length runs, rare resets.
      tmr[0] = 1; tmr[1] = 1;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) begin
            tmr[i]--;
            if (tmr[i] == 0) begin
               key_in_n[i] = ~key_in_n[i];
               tmr[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                    : $urandom_range(4, 60);
            end
         end
         rst_n = ($urandom_range(0, 499) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      idle(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
